// File: rtl/ifu_pkg.sv
// Shared widths and types for the IFU instruction-line cache.
package ifu_pkg;
   localparam int ADDR_WIDTH   = 32;
   localparam int LINE_WIDTH   = 128;
   localparam int OFFSET_WIDTH = 4;
   localparam int TAG_WIDTH    = ADDR_WIDTH - OFFSET_WIDTH;
   localparam int NUM_LINES    = 4;
   localparam int NUM_TAGS     = NUM_LINES;
   localparam int P_BITS       = $clog2(NUM_LINES);
   localparam int TREE_BITS    = NUM_LINES - 1;

   typedef logic [TAG_WIDTH-1:0]  tag_t;
   typedef logic [LINE_WIDTH-1:0] line_t;
   typedef logic [P_BITS-1:0]     way_t;
   typedef logic [TREE_BITS-1:0]  tree_t;
endpackage

// File: rtl/ifu_plru_tree.sv
// Tree pseudo-LRU state for four ways: tree = {b2, b1, b0}, b0 is the root.
module ifu_plru_tree
   import ifu_pkg::*;
(
   input  logic  Clock,
   input  logic  Rst,
   input  logic  touch_valid,
   input  way_t  touch_way,
   output tree_t tree,
   output way_t  victim
);

   tree_t tree_q;
   tree_t tree_d;

   // Touching a way points every node on its path away from it.
   always_comb begin
      // NOTE: defaulting every comb output first keeps this block latch-free.
      tree_d = tree_q;
      if (touch_valid) begin
         case (touch_way)
            2'd0:    begin tree_d[0] = 1'b1; tree_d[1] = 1'b1; end
            2'd1:    begin tree_d[0] = 1'b1; tree_d[1] = 1'b0; end
            2'd2:    begin tree_d[0] = 1'b0; tree_d[2] = 1'b1; end
            default: begin tree_d[0] = 1'b0; tree_d[2] = 1'b0; end
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) tree_q <= '0;
      else      tree_q <= tree_d;
   end

   always_comb begin
      tree   = tree_q;
      victim = tree_q[0] ? (tree_q[2] ? 2'd3 : 2'd2) : (tree_q[1] ? 2'd1 : 2'd0);
   end

endmodule

// File: rtl/ifu_plru_cache.sv
// Fully associative 4-way instruction-line cache with combinational lookup and PLRU refill.
module ifu_plru_cache
   import ifu_pkg::*;
(
   input  logic                            Clock,
   input  logic                            Rst,
   input  logic [ADDR_WIDTH-1:0]           cpu_reqAddrIn,
   output logic [ADDR_WIDTH-1:0]           cpu_rspAddrOut,
   output logic [LINE_WIDTH-1:0]           cpu_rspInsLineOut,
   output logic                            cpu_rspInsLineValidOut,
   input  logic [TAG_WIDTH-1:0]            mem_rspTagIn,
   input  logic [LINE_WIDTH-1:0]           mem_rspInsLineIn,
   input  logic                            mem_rspInsLineValidIn,
   output logic [TAG_WIDTH-1:0]            mem_reqTagOut,
   output logic                            mem_reqTagValidOut,
   output logic                            dataInsertion,
   output logic                            hitStatusOut,
   output logic [TREE_BITS-1:0]            plruTreeOut,
   output logic [LINE_WIDTH*NUM_LINES-1:0] debug_dataArray,
   output logic [(TAG_WIDTH+1)*NUM_TAGS-1:0] debug_tagArray,
   output logic [TREE_BITS-1:0]            debug_plruTree,
   output logic [P_BITS-1:0]               debug_plruIndex
);

   logic [NUM_LINES-1:0] valid_q, valid_d;
   tag_t                 tag_q  [NUM_TAGS];
   tag_t                 tag_d  [NUM_TAGS];
   line_t                data_q [NUM_LINES];
   line_t                data_d [NUM_LINES];
   logic                 ins_q, ins_d;

   tag_t  req_tag;
   logic  hit, fill_match, free_found;
   way_t  hit_way, match_way, free_way, fill_way, victim;
   tree_t tree;

   always_comb begin
      req_tag    = cpu_reqAddrIn[ADDR_WIDTH-1:OFFSET_WIDTH];
      hit        = 1'b0;
      hit_way    = '0;
      fill_match = 1'b0;
      match_way  = '0;
      free_found = 1'b0;
      free_way   = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         if (valid_q[i] && tag_q[i] == req_tag) begin
            hit     = 1'b1;
            hit_way = way_t'(i);
         end
         if (valid_q[i] && tag_q[i] == mem_rspTagIn) begin
            fill_match = 1'b1;
            match_way  = way_t'(i);
         end
      end
      // Scan downward so the lowest-index invalid way wins.
      for (int i = NUM_LINES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_way   = way_t'(i);
         end
      end
      fill_way = fill_match ? match_way : (free_found ? free_way : victim);
   end

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      ins_d   = mem_rspInsLineValidIn;
      if (mem_rspInsLineValidIn) begin
         valid_d[fill_way] = 1'b1;
         tag_d[fill_way]   = mem_rspTagIn;
         data_d[fill_way]  = mem_rspInsLineIn;
      end
   end

   // NOTE: the line storage is reset too, since the debug ports must read all-zero after reset.
   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         valid_q <= '0;
         ins_q   <= 1'b0;
         for (int i = 0; i < NUM_LINES; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         ins_q   <= ins_d;
      end
   end

   // A fill owns the touch port; a hit only touches on a fill-free edge.
   ifu_plru_tree u_plru_tree (
      .Clock       (Clock),
      .Rst         (Rst),
      .touch_valid (mem_rspInsLineValidIn | hit),
      .touch_way   (mem_rspInsLineValidIn ? fill_way : hit_way),
      .tree        (tree),
      .victim      (victim)
   );

   always_comb begin
      cpu_rspAddrOut         = cpu_reqAddrIn;
      cpu_rspInsLineOut      = hit ? data_q[hit_way] : '0;
      cpu_rspInsLineValidOut = hit;
      hitStatusOut           = hit;
      mem_reqTagValidOut     = !hit;
      mem_reqTagOut          = hit ? '0 : req_tag;
      dataInsertion          = ins_q;
      plruTreeOut            = tree;
      debug_plruTree         = tree;
      debug_plruIndex        = victim;
      debug_dataArray        = '0;
      debug_tagArray         = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
         debug_dataArray[i*LINE_WIDTH +: LINE_WIDTH]   = data_q[i];
         debug_tagArray[i*(TAG_WIDTH+1) +: TAG_WIDTH+1] = {valid_q[i], tag_q[i]};
      end
   end

endmodule

// File: tb/tb_ifu_plru_cache.sv
// Self-checking bench for ifu_plru_cache: vector tables plus reset corner sequences.
module tb_ifu_plru_cache;
   import ifu_pkg::*;

   logic         Clock = 1'b0;
   logic         Rst   = 1'b0;
   logic [31:0]  cpu_addr  = '0;
   logic [27:0]  mem_tag   = '0;
   logic [127:0] mem_data  = '0;
   logic         mem_valid = 1'b0;

   logic [31:0]  rsp_addr;
   logic [127:0] rsp_line;
   logic         rsp_valid, req_valid, ins, hit_status;
   logic [27:0]  req_tag;
   logic [2:0]   tree_out, dbg_tree;
   logic [511:0] dbg_data;
   logic [115:0] dbg_tag;
   logic [1:0]   dbg_idx;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string        name;
      logic [31:0]  addr;
      logic         fill;
      logic [27:0]  ftag;
      logic [127:0] fdata;
      logic         exp_hit;
      logic [127:0] exp_line;
      logic [2:0]   exp_tree;
      logic [1:0]   exp_victim;
   } vec_t;

   typedef struct {
      string      name;
      logic [2:0] tree;
      logic [1:0] victim;
      logic       ins;
   } post_t;

   post_t sb_q[$];
   vec_t  ta[$];
   vec_t  tb1[$];
   vec_t  tb2[$];

   localparam logic [127:0] D1  = {4{32'hDEADBEEF}};
   localparam logic [127:0] D1B = {4{32'hCAFEF00D}};
   localparam logic [127:0] D2  = {4{32'h12345678}};
   localparam logic [127:0] L1  = {16{8'h01}};
   localparam logic [127:0] L2  = {16{8'h02}};
   localparam logic [127:0] L3  = {16{8'h03}};
   localparam logic [127:0] L4  = {16{8'h04}};
   localparam logic [127:0] L5  = {16{8'h05}};
   localparam logic [127:0] LF  = {16{8'hFF}};

   ifu_plru_cache dut (
      .Clock                  (Clock),
      .Rst                    (Rst),
      .cpu_reqAddrIn          (cpu_addr),
      .cpu_rspAddrOut         (rsp_addr),
      .cpu_rspInsLineOut      (rsp_line),
      .cpu_rspInsLineValidOut (rsp_valid),
      .mem_rspTagIn           (mem_tag),
      .mem_rspInsLineIn       (mem_data),
      .mem_rspInsLineValidIn  (mem_valid),
      .mem_reqTagOut          (req_tag),
      .mem_reqTagValidOut     (req_valid),
      .dataInsertion          (ins),
      .hitStatusOut           (hit_status),
      .plruTreeOut            (tree_out),
      .debug_dataArray        (dbg_data),
      .debug_tagArray         (dbg_tag),
      .debug_plruTree         (dbg_tree),
      .debug_plruIndex        (dbg_idx)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string n, input logic [31:0] a, input logic f,
                               input logic [27:0] t, input logic [127:0] d, input logic h,
                               input logic [127:0] l, input logic [2:0] tr, input logic [1:0] vi);
      vec_t v;
      v.name = n; v.addr = a; v.fill = f; v.ftag = t; v.fdata = d;
      v.exp_hit = h; v.exp_line = l; v.exp_tree = tr; v.exp_victim = vi;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      post_t p;
      @(negedge Clock);
      cpu_addr  = v.addr;
      mem_valid = v.fill;
      mem_tag   = v.ftag;
      mem_data  = v.fdata;
      sb_q.push_back('{v.name, v.exp_tree, v.exp_victim, v.fill});
      #1;
      check({v.name, " echo"}, rsp_addr, v.addr);
      check({v.name, " hit"}, rsp_valid, v.exp_hit);
      check({v.name, " hitstatus"}, hit_status, v.exp_hit);
      check({v.name, " line"}, rsp_line, v.exp_hit ? v.exp_line : 128'h0);
      check({v.name, " reqvalid"}, req_valid, !v.exp_hit);
      check({v.name, " reqtag"}, req_tag, v.exp_hit ? 28'h0 : v.addr[31:4]);
      @(posedge Clock);
      #1;
      if (sb_q.size() == 0) begin
         check({v.name, " scoreboard_empty"}, 1'b1, 1'b0);
      end else begin
         p = sb_q.pop_front();
         check({p.name, " tree"}, tree_out, p.tree);
         check({p.name, " dbg_tree"}, dbg_tree, p.tree);
         check({p.name, " victim"}, dbg_idx, p.victim);
         check({p.name, " insertion"}, ins, p.ins);
      end
   endtask

   task automatic run(input vec_t q[$]);
      foreach (q[i]) apply(q[i]);
   endtask

   task automatic check_way(input string n, input int w, input logic v, input logic [27:0] t,
                            input logic [127:0] d);
      check({n, " tag"}, dbg_tag[w*29 +: 29], {v, t});
      check({n, " data"}, dbg_data[w*128 +: 128], d);
   endtask

   initial begin
      ta.push_back(mk("a_reset_miss", 32'h0,    0, 28'h0,   '0,  0, '0,  3'b000, 2'd0));
      ta.push_back(mk("a_fill_1000",  32'h1000, 1, 28'h100, D1,  0, '0,  3'b011, 2'd2));
      ta.push_back(mk("a_hit_1000",   32'h1000, 0, 28'h0,   '0,  1, D1,  3'b011, 2'd2));
      ta.push_back(mk("a_refill_100", 32'h1000, 1, 28'h100, D1B, 1, D1,  3'b011, 2'd2));
      ta.push_back(mk("a_hit_new",    32'h1000, 0, 28'h0,   '0,  1, D1B, 3'b011, 2'd2));

      tb1.push_back(mk("b_fill_00", 32'h00, 1, 28'h0, L1, 0, '0, 3'b011, 2'd2));
      tb1.push_back(mk("b_fill_10", 32'h10, 1, 28'h1, L2, 0, '0, 3'b001, 2'd2));
      tb1.push_back(mk("b_fill_20", 32'h20, 1, 28'h2, L3, 0, '0, 3'b100, 2'd0));
      tb1.push_back(mk("b_fill_30", 32'h30, 1, 28'h3, L4, 0, '0, 3'b000, 2'd0));

      tb2.push_back(mk("b_fill_ffff", 32'hFFFF, 1, 28'hFFF, LF, 0, '0, 3'b011, 2'd2));
      tb2.push_back(mk("b_hit_ffff",  32'hFFFF, 0, 28'h0,   '0, 1, LF, 3'b011, 2'd2));
      tb2.push_back(mk("b_miss_0",    32'h0,    0, 28'h0,   '0, 0, '0, 3'b011, 2'd2));
      tb2.push_back(mk("b_hit_fill",  32'h30,   1, 28'h4,   L5, 1, L4, 3'b110, 2'd1));
      tb2.push_back(mk("b_hit_40",    32'h40,   0, 28'h0,   '0, 1, L5, 3'b110, 2'd1));
      tb2.push_back(mk("b_hit_10",    32'h10,   0, 28'h0,   '0, 1, L2, 3'b101, 2'd3));
      tb2.push_back(mk("b_miss_20",   32'h20,   0, 28'h0,   '0, 0, '0, 3'b101, 2'd3));

      repeat (2) @(negedge Clock);
      Rst = 1'b1;
      #1;
      check("reset tree", tree_out, 3'b000);
      check("reset victim", dbg_idx, 2'd0);
      check("reset tags", dbg_tag, 116'h0);
      check("reset data", dbg_data, 512'h0);
      check("reset insertion", ins, 1'b0);

      // Same-tag refill overwrites way0 and leaves the others untouched.
      run(ta);
      check_way("a_way0", 0, 1'b1, 28'h100, D1B);
      check_way("a_way1", 1, 1'b0, 28'h0, '0);
      check_way("a_way2", 2, 1'b0, 28'h0, '0);
      check_way("a_way3", 3, 1'b0, 28'h0, '0);

      // A new tag goes to the lowest free way even though the victim is way2.
      apply(mk("a_fill_free", 32'h2000, 1, 28'h200, D2, 0, '0, 3'b001, 2'd2));
      check_way("a_free_way1", 1, 1'b1, 28'h200, D2);
      check_way("a_free_way2", 2, 1'b0, 28'h0, '0);

      // Asynchronous reset mid-operation while a fill is still being presented.
      #1 Rst = 1'b0;
      #1;
      check("midreset insertion", ins, 1'b0);
      check("midreset tree", tree_out, 3'b000);
      check("midreset tags", dbg_tag, 116'h0);
      check("midreset data", dbg_data, 512'h0);
      check("midreset miss", req_valid, 1'b1);
      @(posedge Clock);
      #1;
      check("midreset no fill tags", dbg_tag, 116'h0);
      check("midreset no fill ins", ins, 1'b0);
      @(negedge Clock);
      mem_valid = 1'b0;
      Rst = 1'b1;

      run(tb1);
      check_way("b_way0", 0, 1'b1, 28'h0, L1);
      check_way("b_way1", 1, 1'b1, 28'h1, L2);
      check_way("b_way2", 2, 1'b1, 28'h2, L3);
      check_way("b_way3", 3, 1'b1, 28'h3, L4);

      run(tb2);
      check_way("b_evict_way0", 0, 1'b1, 28'hFFF, LF);
      check_way("b_evict_way2", 2, 1'b1, 28'h4, L5);
      check_way("b_keep_way3", 3, 1'b1, 28'h3, L4);

      @(negedge Clock);
      mem_valid = 1'b0;
      check("scoreboard drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
